wb_write_unit: RTL and testbench
================================

# wb_write_unit

Write-back stage that owns the register file write port (`a3`/`we3`/`wd3`). It merges single-cycle ALU results with variable-latency load responses into one registered write per cycle and buffers loads in a small queue. It also tracks registers with an outstanding load in a scoreboard so decode can stall on read-after-write hazards. It sits between the execute/memory stages and the register file write inputs.

## Interface
- `DATA_W`, 32, data width of results and `wd3`
- `ADDR_W`, 5, register index width (32 registers)
- `LQ_DEPTH`, 2, load queue entries; power of two, ≥2

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `ld_valid`  in  1  load response valid
- `ld_ready`  out  1  load response accepted when `ld_valid & ld_ready`
- `ld_rd`  in  ADDR_W  load destination register
- `ld_data`  in  DATA_W  load data
- `iss_valid`  in  1  a load is being issued this cycle
- `iss_rd`  in  ADDR_W  destination of the issued load
- `q_a1`, `q_a2`  in  ADDR_W  decode source registers to check
- `hz1`, `hz2`  out  1  source register has a pending load (combinational)
- `a3`  out  ADDR_W  register file write address (registered)
- `we3`  out  1  register file write enable (registered)
- `wd3`  out  DATA_W  register file write data (registered)

## Operation
- **Write select, every cycle:**
  - if `alu_valid` and `alu_rd != 0`, the ALU write wins;
  - else if the queue is non-empty, pop the head and write it;
  - else `we3 <= 0`.
- `a3`/`wd3` hold their last values when `we3 = 0`.
- ALU results with `alu_rd = 0` are dropped. They do not block a queue pop that cycle.
- **Load queue:** circular FIFO of {rd, data}.
  - `ld_ready = !full && !rst`.
  - There is no pass-through when full, even if a pop occurs the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `LQ_DEPTH`.
- A handshake with `ld_rd = 0` is accepted but not stored. It does not change the count.
- **Scoreboard:** `pend[31:0]`, with `pend[0]` hardwired to 0.
  - Set: `iss_valid && iss_rd != 0` sets `pend[iss_rd]`.
  - Clear: `pend[a]` clears on the edge where a popped queue entry with rd = a is written.
  - Set and clear of the same index in one cycle: set wins.
  - ALU writes never touch `pend` (WAW ordering is the issuer's responsibility).
- `hz1 = pend[q_a1]`, `hz2 = pend[q_a2]`. These are pure lookups and do not reflect same-cycle set/clear.
- ALU has strict priority. A continuously valid ALU stalls loads via `ld_ready` once the queue fills. No starvation counter.

## Timing
- **Reset** (async assert, sync release):
  - `we3 = 0`, `a3 = 0`, `wd3 = 0`;
  - queue empty, pointers 0, `pend = 0`;
  - `ld_ready = 0` while `rst` is high;
  - `hz1 = hz2 = 0`.
- Reset mid-operation discards all queued loads and pending bits, with no write issued.
- **ALU latency:** `alu_valid` sampled at edge N gives `we3`/`a3`/`wd3` valid after edge N.
- **Load latency:**
  - handshake at edge N, queue empty, no ALU at N+1: write after edge N+1 (2 cycles);
  - each cycle of ALU conflict adds 1 cycle.
- **Pending bit:**
  - set by issue at edge N: `hz` high from after edge N;
  - cleared on the same edge the load's `we3` rises.
- At most one register file write per cycle.
- Queue order is strict FIFO.

## Test plan
- **Reset:** assert `rst` async mid-cycle with 2 queued loads and `pend[5] = 1` → `we3`, `a3`, `wd3`, `ld_ready`, `hz1` all 0 immediately; after release `ld_ready = 1` and no write of queued data ever appears.
- **ALU path:** `alu_valid = 1`, `alu_rd = 3`, `alu_data = 0xDEADBEEF` for one cycle → next cycle `we3 = 1`, `a3 = 3`, `wd3 = 0xDEADBEEF`; `alu_rd = 0` → `we3 = 0`.
- **Priority/backpressure:**
  - hold ALU valid (`rd = 1`) for 4 cycles while presenting loads to rd 7, 8, 9 → loads 7, 8 accepted, `ld_ready` drops to 0;
  - after ALU stops, writes occur in order 7, 8, 9 with matching data.
- **Scoreboard:**
  - issue load to rd 10 → `hz1 = 1` for `q_a1 = 10`;
  - response `0x1234` arrives → `we3` with `a3 = 10` and `hz1` falls on the same edge;
  - `iss_rd = 0` → `hz` stays 0.
- **Set/clear collision:** pop of rd 12 written in the same cycle as a new issue to rd 12 → `pend[12]` remains 1.
- **Wrap-around:**
  - stream 10 loads to rd 1..10 with no ALU traffic → 10 writes in order, data intact, `ld_ready` never glitches;
  - full + simultaneous pop keeps `ld_ready = 0` that cycle.

Source files
------------

// File: rtl/wb_write_unit.sv
// Write-back stage: merges ALU results and queued load responses into a single
// registered register-file write per cycle, and tracks loads still in flight.
module wb_write_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] q_a1,
    input  logic [ADDR_W-1:0] q_a2,
    output logic              hz1,
    output logic              hz2,
    output logic [ADDR_W-1:0] a3,
    output logic              we3,
    output logic [DATA_W-1:0] wd3
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(LQ_DEPTH);

    // Load queue storage; only pointers and count need a reset.
    logic [ENT_W-1:0]  lq_mem [LQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]    count_reg, count_next;

    logic              we3_reg, we3_next;
    logic [ADDR_W-1:0] a3_reg, a3_next;
    logic [DATA_W-1:0] wd3_reg, wd3_next;

    logic [NREG-1:0]   pend_reg, pend_next;

    logic              lq_full;
    logic              lq_empty;
    logic              alu_wr;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head_entry;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;

    assign lq_full    = (count_reg == FULL_CNT);
    assign lq_empty   = (count_reg == '0);
    assign ld_ready   = !lq_full && !rst;

    assign alu_wr     = alu_valid && (alu_rd != '0);
    // A zero-destination load is acknowledged but never occupies a slot.
    assign push       = ld_valid && ld_ready && (ld_rd != '0);
    assign pop        = !alu_wr && !lq_empty;

    assign head_entry = lq_mem[rd_ptr_reg];
    assign head_rd    = head_entry[DATA_W +: ADDR_W];
    assign head_data  = head_entry[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            lq_mem[wr_ptr_reg] <= {ld_rd, ld_data};
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(LQ_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(LQ_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // ALU has strict priority; a3/wd3 hold when nothing is written.
    always_comb begin
        we3_next = 1'b0;
        a3_next  = a3_reg;
        wd3_next = wd3_reg;
        if (alu_wr) begin
            we3_next = 1'b1;
            a3_next  = alu_rd;
            wd3_next = alu_data;
        end else if (pop) begin
            we3_next = 1'b1;
            a3_next  = head_rd;
            wd3_next = head_data;
        end
    end

    // Scoreboard: set on issue, clear on the popped load's write, set wins.
    assign pend_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
            logic set_bit;
            logic clr_bit;
            assign set_bit       = iss_valid && (iss_rd == ADDR_W'(gi));
            assign clr_bit       = pop && (head_rd == ADDR_W'(gi));
            assign pend_next[gi] = set_bit || (pend_reg[gi] && !clr_bit);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            we3_reg    <= 1'b0;
            a3_reg     <= '0;
            wd3_reg    <= '0;
            pend_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            we3_reg    <= we3_next;
            a3_reg     <= a3_next;
            wd3_reg    <= wd3_next;
            pend_reg   <= pend_next;
        end
    end

    assign we3 = we3_reg;
    assign a3  = a3_reg;
    assign wd3 = wd3_reg;
    assign hz1 = pend_reg[q_a1];
    assign hz2 = pend_reg[q_a2];

endmodule

// File: tb/tb_wb_write_unit.sv
// Directed bench for wb_write_unit: reset, ALU path, priority/backpressure,
// scoreboard set/clear, collisions, wrap-around and mid-operation reset.
module tb_wb_write_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        hz1;
    logic        hz2;
    logic [4:0]  a3;
    logic        we3;
    logic [31:0] wd3;

    int checks   = 0;
    int failures = 0;

    wb_write_unit #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_a1(q_a1), .q_a2(q_a2), .hz1(hz1), .hz2(hz2),
        .a3(a3), .we3(we3), .wd3(wd3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        iss_valid = 1'b0; iss_rd = '0; q_a1 = '0; q_a2 = '0;

        // Reset state
        tick(); tick();
        check("rst_we3", 32'(we3), 32'd0);
        check("rst_a3", 32'(a3), 32'd0);
        check("rst_wd3", wd3, 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_hz1", 32'(hz1), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ld_ready", 32'(ld_ready), 32'd1);

        // ALU path
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        tick();
        check("alu_we3", 32'(we3), 32'd1);
        check("alu_a3", 32'(a3), 32'd3);
        check("alu_wd3", wd3, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h55555555;
        tick();
        check("alu_rd0_we3", 32'(we3), 32'd0);
        check("alu_rd0_a3_hold", 32'(a3), 32'd3);
        check("alu_rd0_wd3_hold", wd3, 32'hDEADBEEF);

        // Priority / backpressure: ALU rd1 for 4 cycles, loads 7, 8, 9
        alu_rd = 5'd1; alu_data = 32'hA0000001;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        check("pri_e1_a3", 32'(a3), 32'd1);
        check("pri_e1_ready", 32'(ld_ready), 32'd1);
        ld_rd = 5'd8; ld_data = 32'h88; alu_data = 32'hA0000002;
        tick();
        check("pri_e2_wd3", wd3, 32'hA0000002);
        check("pri_e2_ready", 32'(ld_ready), 32'd0);
        ld_rd = 5'd9; ld_data = 32'h99; alu_data = 32'hA0000003;
        tick();
        check("pri_e3_ready", 32'(ld_ready), 32'd0);
        alu_data = 32'hA0000004;
        tick();
        check("pri_e4_a3", 32'(a3), 32'd1);
        check("pri_full_pop_ready", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        tick();
        check("pri_w7_a3", 32'(a3), 32'd7);
        check("pri_w7_wd3", wd3, 32'h77);
        check("pri_w7_ready", 32'(ld_ready), 32'd1);
        tick();
        check("pri_w8_a3", 32'(a3), 32'd8);
        check("pri_w8_wd3", wd3, 32'h88);
        ld_valid = 1'b0;
        tick();
        check("pri_w9_we3", 32'(we3), 32'd1);
        check("pri_w9_a3", 32'(a3), 32'd9);
        check("pri_w9_wd3", wd3, 32'h99);
        tick();
        check("pri_idle_we3", 32'(we3), 32'd0);

        // Zero-destination load is acknowledged but never written
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hBAD0;
        tick();
        ld_valid = 1'b0;
        check("ld_rd0_ready", 32'(ld_ready), 32'd1);
        tick();
        check("ld_rd0_we3", 32'(we3), 32'd0);

        // Scoreboard
        q_a1 = 5'd10; q_a2 = 5'd11;
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        iss_valid = 1'b0;
        check("sb_hz1_set", 32'(hz1), 32'd1);
        check("sb_hz2_other", 32'(hz2), 32'd0);
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h1234;
        tick();
        ld_valid = 1'b0;
        check("sb_hz1_queued", 32'(hz1), 32'd1);
        check("sb_we3_queued", 32'(we3), 32'd0);
        tick();
        check("sb_wr_we3", 32'(we3), 32'd1);
        check("sb_wr_a3", 32'(a3), 32'd10);
        check("sb_wr_wd3", wd3, 32'h1234);
        check("sb_hz1_clear", 32'(hz1), 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0; q_a1 = 5'd0; q_a2 = 5'd0;
        tick();
        iss_valid = 1'b0;
        check("sb_rd0_hz1", 32'(hz1), 32'd0);

        // Set/clear collision on rd 12
        q_a1 = 5'd12;
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b0;
        check("col_hz_set", 32'(hz1), 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0C;
        tick();
        ld_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b0;
        check("col_wr_a3", 32'(a3), 32'd12);
        check("col_hz_kept", 32'(hz1), 32'd1);
        tick();
        check("col_hz_still", 32'(hz1), 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0D;
        tick();
        ld_valid = 1'b0;
        tick();
        check("col_hz_cleared", 32'(hz1), 32'd0);

        // Wrap-around: 10 back-to-back loads
        ld_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            ld_rd = 5'(i); ld_data = 32'h100 + 32'(i);
            tick();
            check($sformatf("wrap_ready_%0d", i), 32'(ld_ready), 32'd1);
            if (i >= 2) begin
                check($sformatf("wrap_a3_%0d", i - 1), 32'(a3), 32'(i - 1));
                check($sformatf("wrap_wd3_%0d", i - 1), wd3, 32'h100 + 32'(i - 1));
            end
        end
        ld_valid = 1'b0;
        tick();
        check("wrap_a3_10", 32'(a3), 32'd10);
        check("wrap_wd3_10", wd3, 32'h10A);

        // Reset mid-operation with two queued loads and pend[5]
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        iss_valid = 1'b1; iss_rd = 5'd5;
        ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'hD13;
        tick();
        iss_valid = 1'b0;
        ld_rd = 5'd14; ld_data = 32'hD14;
        tick();
        ld_valid = 1'b0;
        q_a1 = 5'd5;
        #1;
        check("mid_pre_hz1", 32'(hz1), 32'd1);
        check("mid_pre_ready", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we3", 32'(we3), 32'd0);
        check("mid_rst_a3", 32'(a3), 32'd0);
        check("mid_rst_wd3", wd3, 32'd0);
        check("mid_rst_ready", 32'(ld_ready), 32'd0);
        check("mid_rst_hz1", 32'(hz1), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mid_no_write_%0d", i), 32'(we3), 32'd0);
        end
        check("mid_hz1_after", 32'(hz1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
